// File: rtl/pulse_transmitter_pkg.sv
// Shared definitions for the pulse transmitter symbol sequencer.
// Symbol word layout, MSB to LSB: {last, level, prescaler[PS_W], duration[TIMER_WIDTH]}.
package pulse_transmitter_pkg;

   // Sequencer states: IDLE waits for start, LOAD captures a symbol,
   // ARM enables the timer, RUN waits for the timer pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ARM  = 2'd2,
      RUN  = 2'd3
   } state_e;

   // Duration sits at the bottom of the symbol word.
   localparam int SYM_DUR_LSB = 0;

   // Prescaler field sits directly above the duration field.
   function automatic int sym_ps_lsb(input int timer_width);
      return SYM_DUR_LSB + timer_width;
   endfunction

   // Level bit sits directly above the prescaler field.
   function automatic int sym_level_bit(input int ps_w, input int timer_width);
      return sym_ps_lsb(timer_width) + ps_w;
   endfunction

   // Last-symbol flag is the MSB of the word.
   function automatic int sym_last_bit(input int ps_w, input int timer_width);
      return sym_level_bit(ps_w, timer_width) + 1;
   endfunction

   // Total width of one symbol word.
   function automatic int sym_width(input int ps_w, input int timer_width);
      return sym_last_bit(ps_w, timer_width) + 1;
   endfunction

endpackage

// File: rtl/pulse_transmitter_sequencer.sv
// Symbol sequencer for the pulse transmitter: walks a symbol program held in an
// external RAM, drives the sibling countdown timer one symbol at a time, loops
// the program and drives the transmit pin.
// Optional feature macro: PULSE_TRANSMITTER_INFINITE_LOOP_EN (loop_count all-ones
// repeats forever when defined; otherwise it is an ordinary repetition count).
module pulse_transmitter_sequencer
   import pulse_transmitter_pkg::*;
#(
   parameter int  NUM_SYMBOLS     = 16,
   parameter int  PRESCALER_WIDTH = 15,
   parameter int  TIMER_WIDTH     = 8,
   parameter int  LOOP_WIDTH      = 8,
   localparam int ADDR_W          = $clog2(NUM_SYMBOLS),
   localparam int PS_W            = $clog2(PRESCALER_WIDTH + 1),
   localparam int SYM_W           = sym_width(PS_W, TIMER_WIDTH)
)(
   input  logic                   clk,
   input  logic                   sys_rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [ADDR_W-1:0]      start_addr,
   input  logic [LOOP_WIDTH-1:0]  loop_count,
   input  logic                   idle_level,
   output logic [ADDR_W-1:0]      sym_addr,
   input  logic [SYM_W-1:0]       sym_data,
   output logic                   timer_en,
   output logic [PS_W-1:0]        timer_prescaler,
   output logic [TIMER_WIDTH-1:0] timer_duration,
   input  logic                   timer_pulse,
   output logic                   tx_out,
   output logic                   busy,
   output logic                   done
);

   localparam int SYM_PS_LSB    = sym_ps_lsb(TIMER_WIDTH);
   localparam int SYM_LEVEL_BIT = sym_level_bit(PS_W, TIMER_WIDTH);
   localparam int SYM_LAST_BIT  = sym_last_bit(PS_W, TIMER_WIDTH);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      sym_addr_q, sym_addr_d;
   logic [LOOP_WIDTH-1:0]  loops_left_q, loops_left_d;
   logic                   level_q, level_d;
   logic                   last_q, last_d;
   logic                   timer_en_q, timer_en_d;
   logic [PS_W-1:0]        timer_prescaler_q, timer_prescaler_d;
   logic [TIMER_WIDTH-1:0] timer_duration_q, timer_duration_d;
   logic                   tx_out_q, tx_out_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   forever_s;

`ifdef PULSE_TRANSMITTER_INFINITE_LOOP_EN
   // An all-ones repetition count means the program never ends by itself.
   assign forever_s = (loops_left_q == {LOOP_WIDTH{1'b1}});
`else
   assign forever_s = 1'b0;
`endif

   // Next-state and registered-output logic for the sequencer.
   always_comb begin
      state_d           = state_q;
      sym_addr_d        = sym_addr_q;
      loops_left_d      = loops_left_q;
      level_d           = level_q;
      last_d            = last_q;
      timer_en_d        = timer_en_q;
      timer_prescaler_d = timer_prescaler_q;
      timer_duration_d  = timer_duration_q;
      tx_out_d          = tx_out_q;
      done_d            = 1'b0;

      case (state_q)
         IDLE: begin
            tx_out_d   = idle_level;
            timer_en_d = 1'b0;
            if (start && !stop) begin
               sym_addr_d   = start_addr;
               loops_left_d = loop_count;
               state_d      = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (stop) begin
               state_d    = IDLE;
               timer_en_d = 1'b0;
               tx_out_d   = idle_level;
            end else begin
               // Timer inputs settle here, one cycle ahead of the enable.
               timer_prescaler_d = sym_data[SYM_PS_LSB +: PS_W];
               timer_duration_d  = sym_data[SYM_DUR_LSB +: TIMER_WIDTH];
               level_d           = sym_data[SYM_LEVEL_BIT];
               last_d            = sym_data[SYM_LAST_BIT];
               state_d           = ARM;
            end
         end
         ARM: begin
            if (stop) begin
               state_d    = IDLE;
               timer_en_d = 1'b0;
               tx_out_d   = idle_level;
            end else begin
               timer_en_d = 1'b1;
               tx_out_d   = level_q;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               // Abort takes priority over a coincident timer pulse.
               state_d    = IDLE;
               timer_en_d = 1'b0;
               tx_out_d   = idle_level;
            end else if (timer_pulse) begin
               timer_en_d = 1'b0;
               if (!last_q) begin
                  // Address wraps naturally because the RAM depth is a power of 2.
                  sym_addr_d = sym_addr_q + ADDR_W'(1);
                  state_d    = LOAD;
               end else if (loops_left_q != {LOOP_WIDTH{1'b0}}) begin
                  if (forever_s) begin
                     loops_left_d = loops_left_q;
                  end else begin
                     loops_left_d = loops_left_q - LOOP_WIDTH'(1);
                  end
                  sym_addr_d = start_addr;
                  state_d    = LOAD;
               end else begin
                  tx_out_d = idle_level;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d    = IDLE;
            timer_en_d = 1'b0;
            tx_out_d   = idle_level;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state_q           <= IDLE;
         sym_addr_q        <= {ADDR_W{1'b0}};
         loops_left_q      <= {LOOP_WIDTH{1'b0}};
         level_q           <= 1'b0;
         last_q            <= 1'b0;
         timer_en_q        <= 1'b0;
         timer_prescaler_q <= {PS_W{1'b0}};
         timer_duration_q  <= {TIMER_WIDTH{1'b0}};
         tx_out_q          <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         sym_addr_q        <= sym_addr_d;
         loops_left_q      <= loops_left_d;
         level_q           <= level_d;
         last_q            <= last_d;
         timer_en_q        <= timer_en_d;
         timer_prescaler_q <= timer_prescaler_d;
         timer_duration_q  <= timer_duration_d;
         tx_out_q          <= tx_out_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
      end
   end

   assign sym_addr        = sym_addr_q;
   assign timer_en        = timer_en_q;
   assign timer_prescaler = timer_prescaler_q;
   assign timer_duration  = timer_duration_q;
   assign tx_out          = tx_out_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Self-checking bench for pulse_transmitter_sequencer with a behavioural
// countdown timer and symbol RAM. Honours PULSE_TRANSMITTER_INFINITE_LOOP_EN.
module tb_pulse_transmitter_sequencer;

   localparam int NS = 16;

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic        start, stop;
   logic [3:0]  start_addr;
   logic [7:0]  loop_count;
   logic        idle_level;
   logic [3:0]  sym_addr;
   logic [13:0] sym_data;
   logic        timer_en;
   logic [3:0]  timer_prescaler;
   logic [7:0]  timer_duration;
   logic        timer_pulse;
   logic        tx_out, busy, done;

   logic [13:0] ram [NS];
   int unsigned tcnt;
   int          done_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   typedef struct {
      bit tx; bit busy; bit en; bit dn; bit chk; int ps; int dur;
   } exp_t;
   exp_t trace[$];

   pulse_transmitter_sequencer dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
      .start_addr(start_addr), .loop_count(loop_count), .idle_level(idle_level),
      .sym_addr(sym_addr), .sym_data(sym_data), .timer_en(timer_en),
      .timer_prescaler(timer_prescaler), .timer_duration(timer_duration),
      .timer_pulse(timer_pulse), .tx_out(tx_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign sym_data = ram[sym_addr];

   // Countdown timer model: pulse is sampled (duration<<prescaler)+2 edges after enable rises.
   always @(posedge clk) begin
      if (!timer_en) begin
         tcnt        <= 0;
         timer_pulse <= 1'b0;
      end else begin
         tcnt        <= tcnt + 1;
         timer_pulse <= ((tcnt + 1) == ((int'(timer_duration) << timer_prescaler) + 1));
      end
   end

   // Count done pulses over the whole run.
   always @(posedge clk) begin
      if (!sys_rst_n) done_cnt <= 0;
      else if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   function automatic logic [13:0] mk(input bit last, input bit lvl, input int ps, input int dur);
      logic [3:0] p; logic [7:0] d;
      p = ps[3:0]; d = dur[7:0];
      return {last, lvl, p, d};
   endfunction

   function automatic void push(input bit tx, input bit b, input bit en, input bit dn,
                                input bit chk, input int ps, input int dur);
      exp_t e;
      e.tx = tx; e.busy = b; e.en = en; e.dn = dn; e.chk = chk; e.ps = ps; e.dur = dur;
      trace.push_back(e);
   endfunction

   // Reference model: expected per-cycle outputs after the start edge.
   task automatic build_trace(input int sa, input int passes, input bit idl, input bit term);
      int addrs[$]; int a; bit prev; int len; logic [13:0] s;
      trace.delete();
      a = sa;
      for (int k = 0; k < NS; k++) begin
         addrs.push_back(a);
         s = ram[a];
         if (s[13]) break;
         a = (a + 1) % NS;
      end
      prev = idl;
      for (int p = 0; p < passes; p++) begin
         foreach (addrs[j]) begin
            s = ram[addrs[j]];
            len = (int'(s[7:0]) << s[11:8]) + 2;
            push(prev, 1, 0, 0, 0, 0, 0);
            push(prev, 1, 0, 0, 1, int'(s[11:8]), int'(s[7:0]));
            for (int c = 0; c < len; c++) push(s[12], 1, 1, 0, 1, int'(s[11:8]), int'(s[7:0]));
            prev = s[12];
         end
      end
      if (term) begin
         push(idl, 0, 0, 1, 0, 0, 0);
         push(idl, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic run_trace(input string name, input int sa, input int lc, input bit idl,
                            input int passes, input bit term, input int glitch);
      logic [3:0] eps; logic [7:0] edur;
      build_trace(sa, passes, idl, term);
      start_addr = sa[3:0]; loop_count = lc[7:0]; idle_level = idl;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < trace.size(); i++) begin
         if (i > 0) @(negedge clk);
         start = (i == glitch);
         n_checks++;
         if ({tx_out, busy, timer_en, done} !== {trace[i].tx, trace[i].busy, trace[i].en, trace[i].dn}) begin
            n_fail++;
            $display("FAIL %s cycle %0d: {tx,busy,en,done}=%b expected %b", name, i,
                     {tx_out, busy, timer_en, done},
                     {trace[i].tx, trace[i].busy, trace[i].en, trace[i].dn});
         end
         if (trace[i].chk) begin
            eps = trace[i].ps[3:0]; edur = trace[i].dur[7:0];
            n_checks++;
            if ({timer_prescaler, timer_duration} !== {eps, edur}) begin
               n_fail++;
               $display("FAIL %s fields cycle %0d: ps/dur=%0d/%0d expected %0d/%0d", name, i,
                        timer_prescaler, timer_duration, eps, edur);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic wait_en(input string name);
      int w = 0;
      while (timer_en !== 1'b1 && w < 200) begin @(negedge clk); w++; end
      n_checks++;
      if (timer_en !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: timer_en=%b expected 1", name, timer_en);
      end
   endtask

   task automatic check_aborted(input string name, input bit idl, input int dc0);
      n_checks++;
      if ({busy, timer_en, tx_out, done} !== {1'b0, 1'b0, idl, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: {busy,en,tx,done}=%b expected %b", name,
                  {busy, timer_en, tx_out, done}, {1'b0, 1'b0, idl, 1'b0});
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt !== dc0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after: done_cnt=%0d busy=%b expected %0d 0", name, done_cnt, busy, dc0);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sym_addr, timer_en, timer_prescaler, timer_duration, tx_out, busy, done} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset: outputs=%h expected 0",
                  {sym_addr, timer_en, timer_prescaler, timer_duration, tx_out, busy, done});
      end
      sys_rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      ram[0] = mk(0, 1, 0, 3);
      ram[1] = mk(1, 0, 0, 5);
      run_trace("two_sym", 0, 0, 1'b1, 1, 1'b1, 5);
      run_trace("two_sym_loop2", 0, 2, 1'b1, 3, 1'b1, 20);
   endtask

   task automatic test_prescaler();
      ram[3] = mk(1, 1, 2, 4);
      run_trace("prescaler", 3, 0, 1'b0, 1, 1'b1, -1);
   endtask

   task automatic test_wrap();
      ram[15] = mk(0, 1, 0, 2);
      ram[0]  = mk(1, 0, 1, 1);
      run_trace("wrap", 15, 0, 1'b1, 1, 1'b1, -1);
   endtask

   task automatic test_random();
      int sa, n, lc; bit idl;
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < NS; k++) ram[k] = mk(1, $urandom_range(1, 0), 0, 0);
         sa = $urandom_range(NS - 1, 0);
         n  = $urandom_range(4, 1);
         lc = $urandom_range(3, 0);
         idl = $urandom_range(1, 0);
         for (int j = 0; j < n; j++)
            ram[(sa + j) % NS] = mk(j == n - 1, $urandom_range(1, 0), $urandom_range(2, 0), $urandom_range(6, 0));
         run_trace("random", sa, lc, idl, lc + 1, 1'b1, -1);
      end
   endtask

   task automatic test_stop();
      int dc0;
      ram[0] = mk(0, 1, 0, 3);
      ram[1] = mk(1, 0, 0, 5);
      start_addr = 4'd0; loop_count = 8'd3; idle_level = 1'b1;
      // stop during RUN
      dc0 = done_cnt;
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
      wait_en("stop_run");
      @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
      check_aborted("stop_run", 1'b1, dc0);
      // stop during LOAD
      dc0 = done_cnt;
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      check_aborted("stop_load", 1'b1, dc0);
      // start and stop together in IDLE
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_run();
      ram[0] = mk(1, 1, 1, 9);
      start_addr = 4'd0; loop_count = 8'd0; idle_level = 1'b1;
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
      wait_en("reset_run");
      sys_rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({sym_addr, timer_en, timer_prescaler, timer_duration, tx_out, busy, done} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_mid_run: outputs=%h expected 0",
                  {sym_addr, timer_en, timer_prescaler, timer_duration, tx_out, busy, done});
      end
      sys_rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_long_loop();
      int dc0;
      ram[0] = mk(1, 1, 0, 0);
`ifdef PULSE_TRANSMITTER_INFINITE_LOOP_EN
      dc0 = done_cnt;
      run_trace("forever", 0, 255, 1'b0, 1000, 1'b0, -1);
      // The next edge also samples a timer pulse; stop must win.
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      check_aborted("forever_stop", 1'b0, dc0);
`else
      dc0 = 0;
      run_trace("loop255", 0, 255, 1'b0, 256, 1'b1, -1);
`endif
   endtask

   initial begin
      sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      start_addr = 4'd0; loop_count = 8'd0; idle_level = 1'b0;
      for (int k = 0; k < NS; k++) ram[k] = 14'd0;
      test_reset();
      test_basic();
      test_prescaler();
      test_wrap();
      test_random();
      test_stop();
      test_reset_mid_run();
      test_long_loop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
